// File: rtl/data_in_fifo_pkg.sv
// Shared widths, mask constant and a log2 helper for the SDRAM write-data input path.
package data_in_fifo_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DQM_W_DEF  = DATA_W_DEF / 8;

    // Every byte masked: the safe mask value before any real word has been popped.
    localparam logic [DQM_W_DEF-1:0] DQM_ALL_MASKED = '1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/data_in_fifo_mem_dp.sv
// Dual-port register array: synchronous write, asynchronous read, no reset.
module data_in_fifo_mem_dp #(
    parameter int WIDTH  = 36,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_dat,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_dat
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
    end

    assign o_rd_dat = r_mem[i_rd_addr];

endmodule

// File: rtl/data_in_fifo.sv
// Host write-data FIFO feeding the SDRAM datapath; data and mask share one memory word
// so they leave together on the registered output stage, one cycle after rd_en.
module data_in_fifo
    import data_in_fifo_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DQM_W     = DATA_W / 8,
    parameter int DEPTH     = 8,
    parameter int AFULL_LVL = DEPTH - 2,
    parameter int CNT_W     = clog2(DEPTH) + 1
) (
    input  logic              clk0,
    input  logic              reset,
    input  logic              flush,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [DATA_W-1:0] datain,
    input  logic [DQM_W-1:0]  dm,
    input  logic              rd_en,
    output logic [DATA_W-1:0] datain2,
    output logic [DQM_W-1:0]  dqm,
    output logic              dout_valid,
    output logic [CNT_W-1:0]  count,
    output logic              almost_full,
    output logic              empty,
    output logic              underflow
);

    localparam int PTR_W  = clog2(DEPTH);
    localparam int WORD_W = DATA_W + DQM_W;

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_datain2;
    logic [DQM_W-1:0]  r_dqm;
    logic              r_dout_valid;
    logic              r_underflow;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [WORD_W-1:0] w_rd_word;

    // Flags come from the registered count only, so host_ready never sees rd_en.
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = host_valid & ~w_full & ~flush;
    assign w_pop   = rd_en & ~w_empty & ~flush;

    data_in_fifo_mem_dp #(
        .WIDTH  (WORD_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .i_clk     (clk0),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_dat  ({dm, datain}),
        .i_rd_addr (r_rd_ptr),
        .o_rd_dat  (w_rd_word)
    );

    always_ff @(posedge clk0 or posedge reset) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_datain2    <= '0;
            r_dqm        <= '1;
            r_dout_valid <= 1'b0;
            r_underflow  <= 1'b0;
        end else if (flush) begin
            // Output registers keep their last word; only the queue is discarded.
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_dout_valid <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_dout_valid <= w_pop;
            r_underflow  <= rd_en & w_empty;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
                r_datain2 <= w_rd_word[DATA_W-1:0];
                r_dqm     <= w_rd_word[DATA_W +: DQM_W];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign host_ready  = ~w_full;
    assign empty       = w_empty;
    assign almost_full = (r_count >= CNT_W'(AFULL_LVL));
    assign count       = r_count;
    assign datain2     = r_datain2;
    assign dqm         = r_dqm;
    assign dout_valid  = r_dout_valid;
    assign underflow   = r_underflow;

endmodule

// File: tb/tb_data_in_fifo.sv
// Scenario bench for data_in_fifo with a queue model of FIFO contents and output stage.
module tb_data_in_fifo;
    import data_in_fifo_pkg::*;

    logic        clk0;
    logic        reset;
    logic        flush;
    logic        host_valid;
    logic        host_ready;
    logic [31:0] datain;
    logic [3:0]  dm;
    logic        rd_en;
    logic [31:0] datain2;
    logic [3:0]  dqm;
    logic        dout_valid;
    logic [3:0]  count;
    logic        almost_full;
    logic        empty;
    logic        underflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [35:0] fifo_q[$];
    logic        m_vld;
    logic        m_uf;
    logic [31:0] m_dat;
    logic [3:0]  m_dqm;

    data_in_fifo dut (
        .clk0        (clk0),
        .reset       (reset),
        .flush       (flush),
        .host_valid  (host_valid),
        .host_ready  (host_ready),
        .datain      (datain),
        .dm          (dm),
        .rd_en       (rd_en),
        .datain2     (datain2),
        .dqm         (dqm),
        .dout_valid  (dout_valid),
        .count       (count),
        .almost_full (almost_full),
        .empty       (empty),
        .underflow   (underflow)
    );

    initial clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    task automatic model_reset();
        fifo_q.delete();
        m_vld = 1'b0;
        m_uf  = 1'b0;
        m_dat = '0;
        m_dqm = DQM_ALL_MASKED;
    endtask

    // Drive one cycle of stimulus, predict its effect, then wait past the edge.
    task automatic cycle(input logic hv, input logic [31:0] d, input logic [3:0] m,
                         input logic re, input logic fl);
        logic do_push, do_pop;
        host_valid = hv;
        datain     = d;
        dm         = m;
        rd_en      = re;
        flush      = fl;
        do_push = hv && (fifo_q.size() != 8) && !fl;
        do_pop  = re && (fifo_q.size() != 0) && !fl;
        m_uf    = re && (fifo_q.size() == 0) && !fl;
        m_vld   = do_pop;
        if (fl) fifo_q.delete();
        if (do_pop) {m_dqm, m_dat} = fifo_q.pop_front();
        if (do_push) fifo_q.push_back({m, d});
        @(posedge clk0);
        #1;
    endtask

    task automatic idle_inputs();
        host_valid = 1'b0;
        rd_en      = 1'b0;
        flush      = 1'b0;
        datain     = '0;
        dm         = '0;
    endtask

    task automatic test_reset();
        cycle(1'b1, 32'h1234_5678, 4'h5, 1'b0, 1'b0);
        cycle(1'b1, 32'h9ABC_DEF0, 4'hA, 1'b1, 1'b0);
        idle_inputs();
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (datain2 !== 32'h0) begin n_fail++; $display("FAIL reset_datain2: got %h expected %h", datain2, 32'h0); end
        n_checks++;
        if (dqm !== 4'hF) begin n_fail++; $display("FAIL reset_dqm: got %h expected %h", dqm, 4'hF); end
        n_checks++;
        if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++;
        if ({empty, host_ready, dout_valid, almost_full, underflow} !== 5'b11000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 11000", {empty, host_ready, dout_valid, almost_full, underflow});
        end
        @(posedge clk0);
        #1;
        reset = 1'b0;
        model_reset();
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
        n_checks++;
        if (dout_valid !== 1'b0 || underflow !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_no_stale_word: got vld=%b uf=%b expected vld=0 uf=1", dout_valid, underflow);
        end
    endtask

    task automatic test_ordered();
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'hA000_0001 + i, 4'(i), 1'b0, 1'b0);
        n_checks++;
        if (count !== 4'd4) begin n_fail++; $display("FAIL ordered_count: got %0d expected 4", count); end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, '0, '0, 1'b1, 1'b0);
            n_checks++;
            if (dout_valid !== 1'b1 || datain2 !== 32'hA000_0001 + i || dqm !== 4'(i)) begin
                n_fail++;
                $display("FAIL ordered_word%0d: got vld=%b %h/%h expected vld=1 %h/%h",
                         i, dout_valid, datain2, dqm, 32'hA000_0001 + i, 4'(i));
            end
        end
        cycle(1'b0, '0, '0, 1'b0, 1'b0);
        n_checks++;
        if (dout_valid !== 1'b0 || datain2 !== 32'hA000_0004 || dqm !== 4'h3) begin
            n_fail++;
            $display("FAIL ordered_hold: got vld=%b %h/%h expected vld=0 a0000004/3", dout_valid, datain2, dqm);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 32'hB000_0000 + i, 4'(i), 1'b0, 1'b0);
            n_checks++;
            if (count !== 4'(i + 1) || almost_full !== (i + 1 >= 6) || host_ready !== (i + 1 < 8)) begin
                n_fail++;
                $display("FAIL full_fill%0d: got cnt=%0d af=%b rdy=%b expected cnt=%0d af=%b rdy=%b",
                         i, count, almost_full, host_ready, i + 1, (i + 1 >= 6), (i + 1 < 8));
            end
        end
        cycle(1'b1, 32'hB000_0008, 4'h8, 1'b1, 1'b0);
        n_checks++;
        if (count !== 4'd7 || host_ready !== 1'b1 || dout_valid !== 1'b1 || datain2 !== 32'hB000_0000) begin
            n_fail++;
            $display("FAIL full_pop_refuse_push: got cnt=%0d rdy=%b vld=%b dat=%h expected cnt=7 rdy=1 vld=1 dat=b0000000",
                     count, host_ready, dout_valid, datain2);
        end
        cycle(1'b1, 32'hB000_0008, 4'h8, 1'b0, 1'b0);
        n_checks++;
        if (count !== 4'd8 || host_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_ninth_accept: got cnt=%0d rdy=%b expected cnt=8 rdy=0", count, host_ready);
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, '0, '0, 1'b1, 1'b0);
            n_checks++;
            if (dout_valid !== m_vld || datain2 !== m_dat || dqm !== m_dqm) begin
                n_fail++;
                $display("FAIL full_drain%0d: got vld=%b %h/%h expected vld=%b %h/%h",
                         i, dout_valid, datain2, dqm, m_vld, m_dat, m_dqm);
            end
        end
        n_checks++;
        if (empty !== 1'b1 || datain2 !== 32'hB000_0008 || dqm !== 4'h8) begin
            n_fail++;
            $display("FAIL full_last_word: got empty=%b %h/%h expected empty=1 b0000008/8", empty, datain2, dqm);
        end
    endtask

    task automatic test_empty();
        cycle(1'b1, 32'hC0DE_0001, 4'h9, 1'b1, 1'b0);
        n_checks++;
        if (underflow !== 1'b1 || count !== 4'd1 || dout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_push_rd: got uf=%b cnt=%0d vld=%b expected uf=1 cnt=1 vld=0", underflow, count, dout_valid);
        end
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
        n_checks++;
        if (dout_valid !== 1'b1 || datain2 !== 32'hC0DE_0001 || dqm !== 4'h9 || empty !== 1'b1 || underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_pop: got vld=%b %h/%h empty=%b uf=%b expected vld=1 c0de0001/9 empty=1 uf=0",
                     dout_valid, datain2, dqm, empty, underflow);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, $urandom, 4'($urandom_range(0, 15)), 1'b1, 1'b0);
            n_checks++;
            if (count !== 4'd3 || dout_valid !== 1'b1 || datain2 !== m_dat || dqm !== m_dqm) begin
                n_fail++;
                $display("FAIL wrap_pair%0d: got cnt=%0d vld=%b %h/%h expected cnt=3 vld=1 %h/%h",
                         i, count, dout_valid, datain2, dqm, m_dat, m_dqm);
            end
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, '0, '0, 1'b1, 1'b0);
            n_checks++;
            if (dout_valid !== 1'b1 || datain2 !== m_dat || dqm !== m_dqm) begin
                n_fail++;
                $display("FAIL wrap_drain%0d: got vld=%b %h/%h expected vld=1 %h/%h",
                         i, dout_valid, datain2, dqm, m_dat, m_dqm);
            end
        end
    endtask

    task automatic test_flush();
        logic [31:0] saved;
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'hD000_0000 + i, 4'hC, 1'b0, 1'b0);
        n_checks++;
        if (count !== 4'd5) begin n_fail++; $display("FAIL flush_fill: got cnt=%0d expected 5", count); end
        saved = m_dat;
        cycle(1'b1, 32'hDEAD_BEEF, 4'h1, 1'b1, 1'b1);
        n_checks++;
        if (count !== 4'd0 || empty !== 1'b1 || dout_valid !== 1'b0 || datain2 !== saved) begin
            n_fail++;
            $display("FAIL flush_clear: got cnt=%0d empty=%b vld=%b dat=%h expected cnt=0 empty=1 vld=0 dat=%h",
                     count, empty, dout_valid, datain2, saved);
        end
        cycle(1'b1, 32'hE000_0001, 4'h6, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
        n_checks++;
        if (dout_valid !== 1'b1 || datain2 !== 32'hE000_0001 || dqm !== 4'h6 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_restart: got vld=%b %h/%h empty=%b expected vld=1 e0000001/6 empty=1",
                     dout_valid, datain2, dqm, empty);
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk0);
        #1;
        reset = 1'b0;
        test_reset();
        test_ordered();
        test_full();
        test_empty();
        test_wrap();
        test_flush();
        idle_inputs();
        repeat (2) @(posedge clk0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_in_fifo.md
Name: data_in_fifo

Overview:
Parametrised host write-data input stage for the SDRAM controller. It accepts host write words with byte masks over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. It delivers data and mask to the SDRAM datapath, pop-aligned, on the same registered stage. This fixes the one-stage data/mask skew of the previous fixed-width input register and adds flow control, occupancy reporting and flush.

Parameters:
DATA_W, 32, host/SDRAM data width in bits; must be a multiple of 8.
DQM_W, DATA_W/8, byte-mask width; one bit per byte.
DEPTH, 8, FIFO entries; power of two, at least 2.
AFULL_LVL, DEPTH-2, occupancy at or above which almost_full is asserted.
CNT_W, clog2(DEPTH)+1, occupancy counter width.

Ports:
clk0  in  1  system clock; all logic on the rising edge.
reset  in  1  asynchronous, active-high reset.
flush  in  1  synchronous clear of FIFO contents.
host_valid  in  1  host presents a write word.
host_ready  out  1  FIFO can accept a word this cycle.
datain  in  DATA_W  host write data.
dm  in  DQM_W  host byte mask; 1 = byte masked (not written).
rd_en  in  1  SDRAM datapath pops one word.
datain2  out  DATA_W  popped data, registered.
dqm  out  DQM_W  popped mask, registered, same cycle as datain2.
dout_valid  out  1  datain2/dqm hold a word popped on the previous cycle.
count  out  CNT_W  current occupancy, 0..DEPTH.
almost_full  out  1  count >= AFULL_LVL.
empty  out  1  count == 0.
underflow  out  1  one-cycle pulse: rd_en asserted while empty.

Behaviour:
- Reset (async assert, deassert sampled on clk0):
  - wr_ptr, rd_ptr and count = 0.
  - datain2 = 0; dqm = all ones, so bytes are masked until real data arrives.
  - dout_valid = 0, underflow = 0.
  - host_ready = 1, empty = 1, almost_full = 0.
  - Memory contents are not reset.
- host_ready = (count != DEPTH), combinational from registered count only; it never depends on rd_en in the same cycle.
- Push: host_valid & host_ready. {datain, dm} is written to mem[wr_ptr], wr_ptr increments modulo DEPTH (natural wrap, pointer width clog2(DEPTH)).
- Pop: rd_en & ~empty.
  - mem[rd_ptr] is loaded into datain2/dqm on that edge, and dout_valid = 1 on the following cycle. Latency is 1 cycle from rd_en to data.
  - rd_ptr increments modulo DEPTH.
- No pop: dout_valid = 0; datain2 and dqm hold their last values.
- Rd_en while empty: no pointer change, dout_valid = 0, underflow pulses high for 1 cycle.
- No write-through bypass: a word pushed in cycle N is poppable from cycle N+1 at the earliest.
- Count update per cycle: +1 on push only, -1 on pop only, unchanged on push and pop together.
- Full with rd_en and host_valid in the same cycle: the pop happens, the push is refused (host_ready was 0), and count becomes DEPTH-1.
- Empty with push and rd_en in the same cycle: the push happens, the pop is refused with an underflow pulse, and count becomes 1.
- Flush (synchronous, highest priority over push and pop):
  - Pointers and count go to 0; dout_valid = 0.
  - datain2/dqm are not cleared.
  - A host word offered in the flush cycle is dropped, even if host_ready = 1.
- Reset mid-burst: all state is discarded immediately (async); no partial word is emitted afterwards.
- Word ordering is strict FIFO. Data and mask always travel together in one memory word of DATA_W+DQM_W bits.

Decomposition:
- Shared package (extend parameter.v): DATA_W and DQM_W defaults, a DQM_ALL_MASKED constant, and a clog2 function.
- Natural sub-module: fifo_mem_dp. A simple dual-port register array of DEPTH x (DATA_W+DQM_W) with a synchronous write port and an asynchronous read port, with no reset. Pointers, count, flags and output registers live in data_in_fifo.

Test Plan:
- Reset/idle: assert reset mid-simulation -> datain2=0, dqm=4'hF, count=0, empty=1, host_ready=1, dout_valid=0.
- Ordered transfer: push 32'hA0000001..32'hA0000004 with dm=4'h0,4'h1,4'h2,4'h3, then rd_en for 4 cycles -> the same words and masks emerge in order, each 1 cycle after its rd_en, with dqm aligned to datain2.
- Full boundary (DEPTH=8): push 8 words -> count=8, host_ready=0, almost_full=1 from count=6. Hold host_valid=1 and pulse rd_en once -> count=7; the 9th word is accepted the following cycle.
- Empty boundary: with count=0, assert host_valid and rd_en together -> underflow pulses, count=1, dout_valid=0. Next cycle rd_en -> the word appears and empty=1.
- Wrap-around: run 20 push/pop pairs with random data at count=3 steady state -> no loss or reordering across pointer wrap; count stays 3.
- Flush: with count=5, assert flush together with host_valid and rd_en -> count=0, empty=1, dout_valid=0 next cycle, and datain2 unchanged.
